wb_tgt_ram: RTL
===============

# wb_tgt_ram

Pipelined Wishbone target with on-chip synchronous RAM. It terminates one target port of the crossbar, consuming the `tgt_*` request signals and returning ACK/ERR with in-order data. It accepts one request per cycle with a fixed, parameterisable response latency, flags out-of-range addresses with ERR, and honours the pipelined stall/termination rules of the crossbar's target interface.

## Interface
- `ADR_WIDTH`, 16: address bus width (word address).
- `DAT_WIDTH`, 16: data bus width.
- `SEL_WIDTH`, 2: byte selects; `DAT_WIDTH/SEL_WIDTH` bits per lane.
- `TGA_WIDTH`, `TGC_WIDTH`, 1: address and cycle tag widths; accepted, ignored.
- `TGWD_WIDTH`, `TGRD_WIDTH`, 1: write and read data tag widths; must be equal.
- `MEM_DEPTH`, 256: number of RAM words; must be ≤ 2^ADR_WIDTH.
- `LATENCY`, 1: accept-to-termination delay in cycles; legal range 1..4.

Ports:
- `clk_i` in 1: module clock.
- `async_rst_i` in 1: asynchronous reset, active high.
- `sync_rst_i` in 1: synchronous reset, active high.
- `tgt_cyc_i`, `tgt_stb_i`, `tgt_we_i`, `tgt_lock_i` in 1 each: cycle, strobe, write enable, lock. Lock is ignored.
- `tgt_sel_i` in SEL_WIDTH: byte selects.
- `tgt_adr_i` in ADR_WIDTH: word address.
- `tgt_dat_i` in DAT_WIDTH: write data.
- `tgt_tga_i` in TGA_WIDTH, `tgt_tgc_i` in TGC_WIDTH: ignored.
- `tgt_tgd_i` in TGWD_WIDTH: write data tag.
- `tgt_ack_o`, `tgt_err_o`, `tgt_rty_o`, `tgt_stall_o` out 1 each: terminations and stall.
- `tgt_dat_o` out DAT_WIDTH: read data.
- `tgt_tgd_o` out TGRD_WIDTH: read data tag.

## Operation
- A request is accepted when `tgt_cyc_i & tgt_stb_i & ~tgt_stall_o`.
- Storage: MEM_DEPTH words, each `DAT_WIDTH+TGWD_WIDTH` bits wide. Contents are not reset.
- In-range access (`tgt_adr_i < MEM_DEPTH`):
  - Write commits in the accept cycle, per selected byte lane.
  - The data tag is written when any select bit is set.
  - Read captures the word and tag in the accept cycle.
- Out-of-range access:
  - No RAM write.
  - Response is ERR with data 0 and tag 0.
- Response pipeline: LATENCY stages. Each stage holds {valid, err, data, tag} and shifts every cycle.
  - The last stage drives `tgt_ack_o = valid & ~err` and `tgt_err_o = valid & err`.
  - `tgt_dat_o`/`tgt_tgd_o` carry the read word on read ACK and are 0 otherwise. Write ACK returns 0.
- `tgt_rty_o` is constant 0. At most one termination is asserted per cycle.
- Cycle abort: while `tgt_cyc_i` is low, all valid bits are cleared on the next edge, so no termination is issued for them. Writes already committed stay committed.
- State machine (`state_reg`):
  - RESET → IDLE unconditionally after one cycle. `tgt_stall_o` = 1 in RESET, 0 otherwise.
  - IDLE → BUSY on accept.
  - BUSY → IDLE when there is no accept this cycle, the response pipeline holds exactly one valid entry, and that entry is terminating now.
  - BUSY → IDLE when `tgt_cyc_i` = 0.
  - Otherwise the state is held. Illegal encoding → RESET.
- `sync_rst_i` has the same effect as async reset, applied at the clock edge.

## Timing
- Reset values:
  - state = RESET, all valid bits = 0.
  - `tgt_ack_o`, `tgt_err_o`, `tgt_rty_o` = 0.
  - `tgt_stall_o` = 1.
  - `tgt_dat_o` = 0, `tgt_tgd_o` = 0.
- A request accepted at edge N terminates in cycle N+LATENCY. Terminations come strictly in request order.
- Throughput: 1 request per cycle. At most LATENCY requests are outstanding; no stall is needed.
- Read-after-write to the same address in cycle N+1 returns the data written at N.
- Reset asserted mid-operation: pending terminations are dropped immediately (async) or at the next edge (sync).
- All outputs are registered except `tgt_stall_o`, which is decoded from `state_reg`.

## Structure
- `wbxbc_pkg`:
  - State encodings: RESET = 2'b00, IDLE = 2'b01, BUSY = 2'b10.
  - Response stage struct typedef {valid, err, dat, tgd}.
- Sub-module `wb_tgt_ram_array`:
  - Single-port byte-lane RAM, parameterised by depth and width.
  - Synchronous read, write-enable per lane.
  - Must be inferable as block RAM.
- Top level: accept decode, range check, response shift register, state machine.

## Test plan
- Reset and first accept (LATENCY=1):
  - During reset: ack=err=rty=0, stall=1, dat_o=0.
  - One cycle after reset release: stall=0.
- Write then read (LATENCY=1):
  - Write 0xA5C3 to adr 0x10 with sel=2'b11, tgd=1 → ack in the next cycle.
  - Read adr 0x10 → ack one cycle later with dat_o=0xA5C3, tgd_o=1.
- Byte lanes: write 0x1234 to adr 3 with sel=2'b11, then 0xFF00 with sel=2'b10 → read returns 0xFF34.
- Back-to-back reads (LATENCY=3): 4 reads on cycles N..N+3 → ack on cycles N+3..N+6 with data in order; stall stays 0.
- Out-of-range address (MEM_DEPTH=256):
  - Read adr 0x0100 → err one cycle later, ack=0, dat_o=0.
  - Write to adr 0x0100, then read adr 0x00 → adr 0 is unchanged.
- Cycle abort (LATENCY=4):
  - Issue 2 reads, drop cyc two cycles later → no ack/err ever appears; state returns to IDLE.
  - New cycle afterwards → normal ack after 4 cycles.

Source files
------------

// File: rtl/wbxbc_pkg.sv
// Shared types for the Wishbone crossbar target blocks.
// Holds the target FSM encoding and the response-stage control bundle.
package wbxbc_pkg;

    typedef enum logic [1:0] {
        ST_RESET = 2'b00,
        ST_IDLE  = 2'b01,
        ST_BUSY  = 2'b10
    } state_t;

    // Control half of a response stage; data and tag ride alongside it.
    typedef struct packed {
        logic valid;
        logic err;
        logic rd;
    } rsp_ctl_t;

endpackage

// File: rtl/wb_tgt_ram_array.sv
// Single-port byte-lane RAM with synchronous read, written as a block-RAM template.
// Ports: i_clk; i_en/i_we/i_sel/i_adr/i_dat/i_tag request; o_dat/o_tag read word.
module wb_tgt_ram_array #(
    parameter int DEPTH = 256,
    parameter int AW    = 8,
    parameter int DAT_W = 16,
    parameter int SEL_W = 2,
    parameter int TAG_W = 1
) (
    input  logic             i_clk,
    input  logic             i_en,
    input  logic             i_we,
    input  logic [SEL_W-1:0] i_sel,
    input  logic [AW-1:0]    i_adr,
    input  logic [DAT_W-1:0] i_dat,
    input  logic [TAG_W-1:0] i_tag,
    output logic [DAT_W-1:0] o_dat,
    output logic [TAG_W-1:0] o_tag
);

    localparam int LANE_W = DAT_W / SEL_W;

    logic [DAT_W-1:0] r_dat_mem [DEPTH];
    logic [TAG_W-1:0] r_tag_mem [DEPTH];
    logic [DAT_W-1:0] r_rd_dat;
    logic [TAG_W-1:0] r_rd_tag;

    // Read-first: a write returns the old word, which the top discards.
    always_ff @(posedge i_clk) begin
        if (i_en) begin
            if (i_we) begin
                for (int l = 0; l < SEL_W; l++) begin
                    if (i_sel[l]) begin
                        r_dat_mem[i_adr][l*LANE_W +: LANE_W] <=
                            i_dat[l*LANE_W +: LANE_W];
                    end
                end
                if (|i_sel) begin
                    r_tag_mem[i_adr] <= i_tag;
                end
            end
            r_rd_dat <= r_dat_mem[i_adr];
            r_rd_tag <= r_tag_mem[i_adr];
        end
    end

    assign o_dat = r_rd_dat;
    assign o_tag = r_rd_tag;

endmodule

// File: rtl/wb_tgt_ram.sv
// Pipelined Wishbone target backed by on-chip RAM, fixed response latency.
// Ports: clk_i, async_rst_i, sync_rst_i; tgt_* request in, ack/err/rty/stall/dat/tgd out.
module wb_tgt_ram
    import wbxbc_pkg::*;
#(
    parameter int ADR_WIDTH  = 16,
    parameter int DAT_WIDTH  = 16,
    parameter int SEL_WIDTH  = 2,
    parameter int TGA_WIDTH  = 1,
    parameter int TGC_WIDTH  = 1,
    parameter int TGWD_WIDTH = 1,
    parameter int TGRD_WIDTH = 1,
    parameter int MEM_DEPTH  = 256,
    parameter int LATENCY    = 1
) (
    input  logic                  clk_i,
    input  logic                  async_rst_i,
    input  logic                  sync_rst_i,
    input  logic                  tgt_cyc_i,
    input  logic                  tgt_stb_i,
    input  logic                  tgt_we_i,
    input  logic                  tgt_lock_i,
    input  logic [SEL_WIDTH-1:0]  tgt_sel_i,
    input  logic [ADR_WIDTH-1:0]  tgt_adr_i,
    input  logic [DAT_WIDTH-1:0]  tgt_dat_i,
    input  logic [TGA_WIDTH-1:0]  tgt_tga_i,
    input  logic [TGC_WIDTH-1:0]  tgt_tgc_i,
    input  logic [TGWD_WIDTH-1:0] tgt_tgd_i,
    output logic                  tgt_ack_o,
    output logic                  tgt_err_o,
    output logic                  tgt_rty_o,
    output logic                  tgt_stall_o,
    output logic [DAT_WIDTH-1:0]  tgt_dat_o,
    output logic [TGRD_WIDTH-1:0] tgt_tgd_o
);

    localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [ADR_WIDTH:0] DEPTH_L = (ADR_WIDTH+1)'(MEM_DEPTH);

    state_t                  r_state;
    state_t                  w_state_nxt;
    rsp_ctl_t                r_ctl [LATENCY];
    rsp_ctl_t                w_last;
    logic [DAT_WIDTH-1:0]    w_dat [LATENCY];
    logic [TGRD_WIDTH-1:0]   w_tgd [LATENCY];
    logic [DAT_WIDTH-1:0]    w_ram_dat;
    logic [TGWD_WIDTH-1:0]   w_ram_tgd;
    logic                    w_accept;
    logic                    w_in_range;
    logic                    w_rd_ack;
    logic                    w_stall;
    logic [2:0]              w_nvalid;
    logic                    w_unused;

    assign w_unused   = ^{tgt_lock_i, tgt_tga_i, tgt_tgc_i};
    assign w_accept   = tgt_cyc_i & tgt_stb_i & ~tgt_stall_o;
    assign w_in_range = {1'b0, tgt_adr_i} < DEPTH_L;

    wb_tgt_ram_array #(
        .DEPTH (MEM_DEPTH),
        .AW    (AW),
        .DAT_W (DAT_WIDTH),
        .SEL_W (SEL_WIDTH),
        .TAG_W (TGWD_WIDTH)
    ) u_array (
        .i_clk (clk_i),
        .i_en  (w_accept & w_in_range),
        .i_we  (tgt_we_i),
        .i_sel (tgt_sel_i),
        .i_adr (tgt_adr_i[AW-1:0]),
        .i_dat (tgt_dat_i),
        .i_tag (tgt_tgd_i),
        .o_dat (w_ram_dat),
        .o_tag (w_ram_tgd)
    );

    // Stage 0 data is the RAM output register itself; later stages copy it.
    assign w_dat[0] = w_ram_dat;
    assign w_tgd[0] = w_ram_tgd;

    for (genvar k = 1; k < LATENCY; k++) begin : g_stage
        logic [DAT_WIDTH-1:0]  r_dat;
        logic [TGRD_WIDTH-1:0] r_tgd;
        always_ff @(posedge clk_i) begin
            r_dat <= w_dat[k-1];
            r_tgd <= w_tgd[k-1];
        end
        assign w_dat[k] = r_dat;
        assign w_tgd[k] = r_tgd;
    end

    // Dropping CYC kills every in-flight response on the next edge.
    always_ff @(posedge clk_i or posedge async_rst_i) begin
        if (async_rst_i) begin
            for (int k = 0; k < LATENCY; k++) r_ctl[k] <= '0;
        end else if (sync_rst_i || !tgt_cyc_i) begin
            for (int k = 0; k < LATENCY; k++) r_ctl[k] <= '0;
        end else begin
            r_ctl[0] <= rsp_ctl_t'{
                valid: w_accept,
                err:   ~w_in_range,
                rd:    ~tgt_we_i
            };
            for (int k = 1; k < LATENCY; k++) r_ctl[k] <= r_ctl[k-1];
        end
    end

    assign w_last    = r_ctl[LATENCY-1];
    assign tgt_ack_o = w_last.valid & ~w_last.err;
    assign tgt_err_o = w_last.valid & w_last.err;
    assign tgt_rty_o = 1'b0;

    // Data stages are never cleared, so the bus only shows them on a read ACK.
    assign w_rd_ack  = tgt_ack_o & w_last.rd;
    assign tgt_dat_o = w_rd_ack ? w_dat[LATENCY-1] : '0;
    assign tgt_tgd_o = w_rd_ack ? w_tgd[LATENCY-1] : '0;

    always_comb begin
        w_nvalid = '0;
        for (int k = 0; k < LATENCY; k++) begin
            w_nvalid = w_nvalid + {2'b00, r_ctl[k].valid};
        end
    end

    always_ff @(posedge clk_i or posedge async_rst_i) begin
        if (async_rst_i) begin
            r_state <= ST_RESET;
        end else if (sync_rst_i) begin
            r_state <= ST_RESET;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_RESET: w_state_nxt = ST_IDLE;
            ST_IDLE: begin
                if (w_accept) w_state_nxt = ST_BUSY;
            end
            ST_BUSY: begin
                if (!tgt_cyc_i) begin
                    w_state_nxt = ST_IDLE;
                end else if (!w_accept && w_nvalid == 3'd1 && w_last.valid) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_RESET;
        endcase
    end

    always_comb begin
        w_stall = (r_state == ST_RESET);
    end

    assign tgt_stall_o = w_stall;

endmodule
